// File: rtl/da_fir_stream.sv
// Distributed-arithmetic FIR: a TAPS-deep sample delay line evaluated bit-serially through
// NUM_ROM loadable partial-sum ROMs, with valid/ready streaming on both sides.
module da_fir_stream #(
    parameter int unsigned NUM_ROM    = 8,
    parameter int unsigned ROM_ADDR_W = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned COEF_W     = 20,
    localparam int unsigned RI_W      = (NUM_ROM > 1) ? $clog2(NUM_ROM) : 1,
    localparam int unsigned ACC_W     = COEF_W + DATA_W + RI_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       coef_we,
    input  logic [RI_W+ROM_ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0]          coef_data,
    output logic                       coef_err,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_signed,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_data
);

    localparam int unsigned TAPS      = NUM_ROM * ROM_ADDR_W;
    localparam int unsigned CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned ROM_WORDS = 2 ** ROM_ADDR_W;

    typedef enum logic [1:0] {StIdle, StCompute, StStall} state_e;

    state_e                         state_q, state_d;
    logic [TAPS-1:0][DATA_W-1:0]    taps_q, taps_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W-1:0]               out_data_q, out_data_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           sgn_q, sgn_d;
    logic                           out_valid_q, out_valid_d;
    logic                           coef_err_q, coef_err_d;

    logic [COEF_W-1:0]              rom_q [NUM_ROM][ROM_WORDS];
    logic [RI_W-1:0]                wr_idx;
    logic [ROM_ADDR_W-1:0]          wr_addr;
    logic                           rom_we;
    logic                           accept;
    logic                           last;
    logic signed [ACC_W-1:0]        psum;
    logic signed [ACC_W-1:0]        term;
    logic signed [ACC_W-1:0]        acc_step;

    assign wr_idx  = coef_addr[ROM_ADDR_W +: RI_W];
    assign wr_addr = coef_addr[ROM_ADDR_W-1:0];
    // Out-of-range ROM indices are silently ignored; only busy-engine writes flag an error.
    assign rom_we  = coef_we && !reset && (state_q == StIdle) && (32'(wr_idx) < NUM_ROM);

    assign in_ready = (state_q == StIdle) && !coef_we && !reset;
    assign accept   = in_valid && in_ready;
    assign last     = (cnt_q == CNT_W'(DATA_W - 1));

    // Coefficient ROMs deliberately have no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (rom_we) begin
            rom_q[wr_idx][wr_addr] <= coef_data;
        end
    end

    // Each ROM is addressed by bit cnt_q of its group of taps.
    always_comb begin
        logic [ROM_ADDR_W-1:0] a;
        logic [COEF_W-1:0]     w;
        psum = '0;
        a    = '0;
        w    = '0;
        for (int k = 0; k < NUM_ROM; k++) begin
            a = '0;
            for (int j = 0; j < ROM_ADDR_W; j++) begin
                a[j] = taps_q[k*ROM_ADDR_W+j][cnt_q];
            end
            w    = rom_q[k][a];
            psum = psum + {{(ACC_W-COEF_W){w[COEF_W-1]}}, w};
        end
    end

    assign term     = psum <<< cnt_q;
    assign acc_step = (sgn_q && last) ? acc_q - term : acc_q + term;

    always_comb begin
        state_d     = state_q;
        taps_d      = taps_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        coef_err_d  = coef_we && (state_q != StIdle);

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    taps_d[0] = in_data;
                    for (int i = 1; i < TAPS; i++) begin
                        taps_d[i] = taps_q[i-1];
                    end
                    sgn_d   = in_signed;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = acc_step;
                if (last) begin
                    if (!out_valid_q || out_ready) begin
                        out_data_d  = acc_step;
                        out_valid_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        state_d = StStall;
                    end
                end
            end
            StStall: begin
                if (out_ready) begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            taps_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            coef_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            taps_q      <= taps_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            coef_err_q  <= coef_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_da_fir_stream.sv
// Bench for da_fir_stream: a small 2x2-tap instance for directed cases and a default 8x8-tap
// instance for random traffic, both checked against a plain dot-product FIR model.
module tb_da_fir_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        c_we;
    logic [10:0] c_addr;
    logic [19:0] c_data;
    logic        iv, isg, ordy;
    logic [7:0]  idat;

    logic        s_ce, s_ir, s_ov;
    logic [28:0] s_od;
    logic        d_ce, d_ir, d_ov;
    logic [30:0] d_od;

    logic               ce, ir, ov;
    logic signed [31:0] od;

    int n_checks = 0;
    int n_err    = 0;

    int          coef [64];
    logic [7:0]  hist [64];

    always #5 clk = ~clk;

    da_fir_stream #(.NUM_ROM(2), .ROM_ADDR_W(2), .DATA_W(8), .COEF_W(20)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .coef_we   (c_we & ~sel),
        .coef_addr (c_addr[2:0]),
        .coef_data (c_data),
        .coef_err  (s_ce),
        .in_valid  (iv & ~sel),
        .in_ready  (s_ir),
        .in_data   (idat),
        .in_signed (isg),
        .out_valid (s_ov),
        .out_ready (ordy | sel),
        .out_data  (s_od)
    );

    da_fir_stream dut_d (
        .clk       (clk),
        .reset     (reset),
        .coef_we   (c_we & sel),
        .coef_addr (c_addr),
        .coef_data (c_data),
        .coef_err  (d_ce),
        .in_valid  (iv & sel),
        .in_ready  (d_ir),
        .in_data   (idat),
        .in_signed (isg),
        .out_valid (d_ov),
        .out_ready (ordy | ~sel),
        .out_data  (d_od)
    );

    assign ce = sel ? d_ce : s_ce;
    assign ir = sel ? d_ir : s_ir;
    assign ov = sel ? d_ov : s_ov;
    assign od = sel ? $signed({d_od[30], d_od}) : $signed({{3{s_od[28]}}, s_od});

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        for (int t = 63; t > 0; t--) hist[t] = hist[t-1];
        hist[0] = d;
    endtask

    task automatic clear_hist;
        for (int t = 0; t < 64; t++) hist[t] = 8'h00;
    endtask

    // Plain FIR: every tap reinterpreted in the mode latched with the newest sample.
    function automatic longint ref_y(input int ntaps, input bit s);
        longint y = 0;
        for (int t = 0; t < ntaps; t++) begin
            y += longint'(coef[t]) * (s ? longint'($signed(hist[t])) : longint'(hist[t]));
        end
        return y;
    endfunction

    task automatic wr(input logic [10:0] a, input logic [19:0] d);
        c_we = 1'b1; c_addr = a; c_data = d;
        tick;
        c_we = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ir && n < 100) begin tick; n++; end
        chk({tag, "_rdy"}, ir, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!ov && n < 100) begin tick; n++; end
        chk({tag, "_vld"}, ov, 1);
    endtask

    task automatic send(input logic [7:0] d, input bit s, input string tag);
        longint e;
        wait_ready(tag);
        iv = 1'b1; idat = d; isg = s;
        tick;
        iv = 1'b0;
        push(d);
        e = ref_y(sel ? 64 : 4, s);
        wait_valid(tag);
        chk(tag, od, e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint e1, e2, hold;
        int     nacc;
        bit     bad;

        reset = 1'b1; sel = 1'b0; c_we = 1'b0; c_addr = '0; c_data = '0;
        iv = 1'b0; isg = 1'b0; idat = '0; ordy = 1'b1;
        clear_hist;
        for (int t = 0; t < 64; t++) coef[t] = 0;
        tick; tick;
        chk("rst_out_valid", ov, 0);
        chk("rst_out_data", od, 0);
        chk("rst_coef_err", ce, 0);
        chk("rst_in_ready", ir, 0);
        reset = 1'b0;
        tick;

        // All-ones coefficients: ROM word = popcount of its address.
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 4; a++) wr(11'((k << 2) | a), 20'($countones(a)));
        for (int t = 0; t < 4; t++) coef[t] = 1;

        send(8'd5, 1'b0, "imp0");
        for (int i = 0; i < 5; i++) send(8'd0, 1'b0, "imp_tail");
        for (int i = 0; i < 5; i++) send(8'd3, 1'b0, "step3");
        for (int i = 0; i < 4; i++) send(8'd0, 1'b0, "flush");
        send(8'hFD, 1'b1, "fd_signed");
        chk("fd_signed_const", od, -3);
        for (int i = 0; i < 4; i++) send(8'd0, 1'b0, "flush");
        send(8'hFD, 1'b0, "fd_unsigned");
        chk("fd_unsigned_const", od, 253);
        for (int i = 0; i < 4; i++) send(8'd0, 1'b0, "flush");

        // Backpressure: consumer stalls 30 cycles while samples are on offer.
        tick;
        ordy = 1'b0; iv = 1'b1; idat = 8'd1; isg = 1'b0;
        nacc = 0; e1 = 0; e2 = 0; bad = 1'b0; hold = 0;
        for (int i = 0; i < 30; i++) begin
            if (ir) begin
                nacc++;
                push(8'd1);
                if (nacc == 1) e1 = ref_y(4, 1'b0); else e2 = ref_y(4, 1'b0);
            end
            tick;
            if (ov && hold == 0) hold = od;
            if (ov && od != hold) bad = 1'b1;
        end
        chk("bp_accepts", nacc, 2);
        chk("bp_held_valid", ov, 1);
        chk("bp_held_data", od, e1);
        chk("bp_stable", bad, 0);
        chk("bp_in_ready_low", ir, 0);
        iv = 1'b0; ordy = 1'b1;
        tick;
        chk("bp_second_valid", ov, 1);
        chk("bp_second_data", od, e2);
        tick;
        chk("bp_drained", ov, 0);
        for (int i = 0; i < 4; i++) send(8'd0, 1'b0, "flush");

        // Coefficient write while busy is dropped and flagged for one cycle.
        wait_ready("busy_wr");
        iv = 1'b1; idat = 8'd6; isg = 1'b0;
        tick;
        iv = 1'b0;
        push(8'd6);
        e1 = ref_y(4, 1'b0);
        wr(11'b001, 20'd99);
        chk("coef_err_pulse", ce, 1);
        tick;
        chk("coef_err_clear", ce, 0);
        wait_valid("busy_wr");
        chk("busy_wr_rom_kept", od, e1);
        for (int i = 0; i < 4; i++) send(8'd0, 1'b0, "flush");

        // Write and sample in the same IDLE cycle: write wins, sample waits.
        wait_ready("wr_win");
        c_we = 1'b1; c_addr = 11'b001; c_data = 20'd2; iv = 1'b1; idat = 8'h55;
        #1;
        chk("wr_win_in_ready", ir, 0);
        tick;
        c_addr = 11'b011; c_data = 20'd3;
        tick;
        c_we = 1'b0; iv = 1'b0;
        chk("wr_win_no_err", ce, 0);
        chk("wr_win_no_out", ov, 0);
        coef[0] = 2;
        for (int i = 0; i < 4; i++) send(8'd0, 1'b0, "flush");
        send(8'd4, 1'b0, "wr_win_tap0");
        wr(11'b001, 20'd1);
        wr(11'b011, 20'd2);
        coef[0] = 1;

        // Reset mid-compute: history cleared, ROMs kept, no stray output.
        wait_ready("mid_rst");
        iv = 1'b1; idat = 8'd9; isg = 1'b0;
        tick;
        iv = 1'b0;
        tick; tick;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", ov, 0);
        chk("mid_rst_ready", ir, 0);
        tick;
        reset = 1'b0;
        clear_hist;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (ov) bad = 1'b1;
        end
        chk("mid_rst_no_spurious", bad, 0);
        send(8'd7, 1'b0, "post_rst_imp");
        chk("post_rst_imp_const", od, 7);
        send(8'd0, 1'b0, "post_rst_tail");

        // Default geometry: random linear coefficients, random samples and modes.
        sel = 1'b1;
        clear_hist;
        tick;
        for (int t = 0; t < 64; t++) coef[t] = int'($urandom_range(120000)) - 60000;
        for (int k = 0; k < 8; k++) begin
            for (int a = 0; a < 256; a++) begin
                int sum;
                sum = 0;
                for (int j = 0; j < 8; j++) if (((a >> j) & 1) == 1) sum += coef[k*8+j];
                wr(11'((k << 8) | a), sum[19:0]);
            end
        end
        for (int i = 0; i < 500; i++) begin
            logic [7:0] d;
            bit         s;
            d = 8'($urandom);
            s = 1'($urandom);
            send(d, s, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
